// File: rtl/pixel_stream_monitor.sv
// pixel_stream_monitor
//   Sink-side checker for a raster pixel stream. Locks onto the raster at
//   (0,0), verifies every following sample advances in raster order, and
//   accumulates per-frame statistics. These are published once per complete
//   frame, with a one-cycle frame_done pulse.
//
// Ports
//   clk_pix            pixel clock, rising edge
//   sim_rst_n          synchronous active-low reset
//   sdl_sx, sdl_sy     current pixel coordinate
//   sdl_de             pixel is drawn
//   sdl_r/g/b          pixel colour
//   locked             high while tracking a continuous raster
//   frame_done         one-cycle pulse after a frame's results are published
//   pix_count          drawn pixels in the last complete frame
//   bbox_valid         last complete frame had at least one drawn pixel
//   bbox_x0/x1/y0/y1   bounding box of drawn pixels (all 0 if none)
//   sum_rgb            sum of r+g+b over drawn pixels, modulo 2^32
//   frame_cnt          number of frames published (wraps)
//   seq_err            sticky raster discontinuity flag
module pixel_stream_monitor #(
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int CNT_W = 19
) (
  input  logic             clk_pix,
  input  logic             sim_rst_n,
  input  logic [9:0]       sdl_sx,
  input  logic [9:0]       sdl_sy,
  input  logic             sdl_de,
  input  logic [7:0]       sdl_r,
  input  logic [7:0]       sdl_g,
  input  logic [7:0]       sdl_b,
  output logic             locked,
  output logic             frame_done,
  output logic [CNT_W-1:0] pix_count,
  output logic             bbox_valid,
  output logic [9:0]       bbox_x0,
  output logic [9:0]       bbox_x1,
  output logic [9:0]       bbox_y0,
  output logic [9:0]       bbox_y1,
  output logic [31:0]      sum_rgb,
  output logic [15:0]      frame_cnt,
  output logic             seq_err
);

  typedef enum logic {HUNT, TRACK} state_t;

  localparam logic [9:0] X_MAX = 10'(H_RES - 1);
  localparam logic [9:0] Y_MAX = 10'(V_RES - 1);

  state_t state_q, state_d;

  // Coordinate the next sample must carry while tracking.
  logic [9:0] exp_x_q, exp_x_d, exp_y_q, exp_y_d;

  // Running accumulators of the frame in progress.
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             any_q, any_d;
  logic [9:0]       x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
  logic [31:0]      sum_q, sum_d;

  // Published results.
  logic             frame_done_q, frame_done_d;
  logic [CNT_W-1:0] pix_count_q, pix_count_d;
  logic             bbox_valid_q, bbox_valid_d;
  logic [9:0]       bx0_q, bx0_d, bx1_q, bx1_d, by0_q, by0_d, by1_q, by1_d;
  logic [31:0]      sum_rgb_q, sum_rgb_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             seq_err_q, seq_err_d;

  // Scratch values for the accumulate path.
  logic [9:0]       rgb_sum;
  logic [9:0]       next_x, next_y;
  logic             at_end;
  logic [CNT_W-1:0] acc_cnt;
  logic             acc_any;
  logic [9:0]       acc_x0, acc_x1, acc_y0, acc_y1;
  logic [31:0]      acc_sum;

  always_comb begin
    state_d      = state_q;
    exp_x_d      = exp_x_q;
    exp_y_d      = exp_y_q;
    cnt_d        = cnt_q;
    any_d        = any_q;
    x0_d         = x0_q;
    x1_d         = x1_q;
    y0_d         = y0_q;
    y1_d         = y1_q;
    sum_d        = sum_q;
    frame_done_d = 1'b0;
    pix_count_d  = pix_count_q;
    bbox_valid_d = bbox_valid_q;
    bx0_d        = bx0_q;
    bx1_d        = bx1_q;
    by0_d        = by0_q;
    by1_d        = by1_q;
    sum_rgb_d    = sum_rgb_q;
    frame_cnt_d  = frame_cnt_q;
    seq_err_d    = seq_err_q;

    rgb_sum = {2'b00, sdl_r} + {2'b00, sdl_g} + {2'b00, sdl_b};
    at_end  = (sdl_sx == X_MAX) && (sdl_sy == Y_MAX);

    // Raster successor of the current sample; only stored when the sample
    // is accepted, so it is always in range.
    if (sdl_sx == X_MAX) begin
      next_x = 10'd0;
      next_y = (sdl_sy == Y_MAX) ? 10'd0 : sdl_sy + 10'd1;
    end else begin
      next_x = sdl_sx + 10'd1;
      next_y = sdl_sy;
    end

    // Accumulate the current sample on top of the running totals. The first
    // drawn pixel of a frame initialises the box instead of min/max-ing
    // against the zeroed registers.
    acc_cnt = cnt_q + CNT_W'(sdl_de);
    acc_any = any_q | sdl_de;
    acc_x0  = x0_q;
    acc_x1  = x1_q;
    acc_y0  = y0_q;
    acc_y1  = y1_q;
    acc_sum = sum_q;
    if (sdl_de) begin
      acc_sum = sum_q + {22'd0, rgb_sum};
      if (!any_q) begin
        acc_x0 = sdl_sx;
        acc_x1 = sdl_sx;
        acc_y0 = sdl_sy;
        acc_y1 = sdl_sy;
      end else begin
        if (sdl_sx < x0_q) acc_x0 = sdl_sx;
        if (sdl_sx > x1_q) acc_x1 = sdl_sx;
        if (sdl_sy < y0_q) acc_y0 = sdl_sy;
        if (sdl_sy > y1_q) acc_y1 = sdl_sy;
      end
    end

    case (state_q)
      HUNT: begin
        // Accumulators are already clear here, so accumulating the (0,0)
        // sample is exactly the seeding step.
        if (sdl_sx == 10'd0 && sdl_sy == 10'd0) begin
          state_d = TRACK;
          exp_x_d = next_x;
          exp_y_d = next_y;
          cnt_d   = acc_cnt;
          any_d   = acc_any;
          x0_d    = acc_x0;
          x1_d    = acc_x1;
          y0_d    = acc_y0;
          y1_d    = acc_y1;
          sum_d   = acc_sum;
        end
      end
      TRACK: begin
        if (sdl_sx == exp_x_q && sdl_sy == exp_y_q) begin
          exp_x_d = next_x;
          exp_y_d = next_y;
          if (at_end) begin
            frame_done_d = 1'b1;
            pix_count_d  = acc_cnt;
            bbox_valid_d = acc_any;
            bx0_d        = acc_x0;
            bx1_d        = acc_x1;
            by0_d        = acc_y0;
            by1_d        = acc_y1;
            sum_rgb_d    = acc_sum;
            frame_cnt_d  = frame_cnt_q + 16'd1;
            cnt_d        = '0;
            any_d        = 1'b0;
            x0_d         = '0;
            x1_d         = '0;
            y0_d         = '0;
            y1_d         = '0;
            sum_d        = '0;
          end else begin
            cnt_d = acc_cnt;
            any_d = acc_any;
            x0_d  = acc_x0;
            x1_d  = acc_x1;
            y0_d  = acc_y0;
            y1_d  = acc_y1;
            sum_d = acc_sum;
          end
        end else begin
          // Discontinuity: drop the partial frame; re-lock only from HUNT.
          seq_err_d = 1'b1;
          state_d   = HUNT;
          cnt_d     = '0;
          any_d     = 1'b0;
          x0_d      = '0;
          x1_d      = '0;
          y0_d      = '0;
          y1_d      = '0;
          sum_d     = '0;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk_pix) begin
    if (!sim_rst_n) begin
      state_q      <= HUNT;
      exp_x_q      <= '0;
      exp_y_q      <= '0;
      cnt_q        <= '0;
      any_q        <= 1'b0;
      x0_q         <= '0;
      x1_q         <= '0;
      y0_q         <= '0;
      y1_q         <= '0;
      sum_q        <= '0;
      frame_done_q <= 1'b0;
      pix_count_q  <= '0;
      bbox_valid_q <= 1'b0;
      bx0_q        <= '0;
      bx1_q        <= '0;
      by0_q        <= '0;
      by1_q        <= '0;
      sum_rgb_q    <= '0;
      frame_cnt_q  <= '0;
      seq_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      exp_x_q      <= exp_x_d;
      exp_y_q      <= exp_y_d;
      cnt_q        <= cnt_d;
      any_q        <= any_d;
      x0_q         <= x0_d;
      x1_q         <= x1_d;
      y0_q         <= y0_d;
      y1_q         <= y1_d;
      sum_q        <= sum_d;
      frame_done_q <= frame_done_d;
      pix_count_q  <= pix_count_d;
      bbox_valid_q <= bbox_valid_d;
      bx0_q        <= bx0_d;
      bx1_q        <= bx1_d;
      by0_q        <= by0_d;
      by1_q        <= by1_d;
      sum_rgb_q    <= sum_rgb_d;
      frame_cnt_q  <= frame_cnt_d;
      seq_err_q    <= seq_err_d;
    end
  end

  assign locked     = (state_q == TRACK);
  assign frame_done = frame_done_q;
  assign pix_count  = pix_count_q;
  assign bbox_valid = bbox_valid_q;
  assign bbox_x0    = bx0_q;
  assign bbox_x1    = bx1_q;
  assign bbox_y0    = by0_q;
  assign bbox_y1    = by1_q;
  assign sum_rgb    = sum_rgb_q;
  assign frame_cnt  = frame_cnt_q;
  assign seq_err    = seq_err_q;

endmodule

// File: tb/tb_pixel_stream_monitor.sv
// tb_pixel_stream_monitor
//   Directed bench for pixel_stream_monitor on a reduced 20x16 raster so that
//   whole frames stay short. Square frame: de over x 5..14, y 3..12 with
//   b=FF -> 100 pixels, sum 25500. White frame: 320 pixels, sum 320*765.
module tb_pixel_stream_monitor;
  localparam int H    = 20;
  localparam int V    = 16;
  localparam int LAST = H * V - 1;

  logic        clk_pix = 1'b0;
  logic        sim_rst_n;
  logic [9:0]  sdl_sx, sdl_sy;
  logic        sdl_de;
  logic [7:0]  sdl_r, sdl_g, sdl_b;
  logic        locked, frame_done, bbox_valid, seq_err;
  logic [18:0] pix_count;
  logic [9:0]  bbox_x0, bbox_x1, bbox_y0, bbox_y1;
  logic [31:0] sum_rgb;
  logic [15:0] frame_cnt;

  int total = 0;
  int bad = 0;
  int done_cnt;

  pixel_stream_monitor #(.H_RES(H), .V_RES(V), .CNT_W(19)) dut (
    .clk_pix(clk_pix), .sim_rst_n(sim_rst_n),
    .sdl_sx(sdl_sx), .sdl_sy(sdl_sy), .sdl_de(sdl_de),
    .sdl_r(sdl_r), .sdl_g(sdl_g), .sdl_b(sdl_b),
    .locked(locked), .frame_done(frame_done), .pix_count(pix_count),
    .bbox_valid(bbox_valid), .bbox_x0(bbox_x0), .bbox_x1(bbox_x1),
    .bbox_y0(bbox_y0), .bbox_y1(bbox_y1), .sum_rgb(sum_rgb),
    .frame_cnt(frame_cnt), .seq_err(seq_err)
  );

  always #5 clk_pix = ~clk_pix;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one sample at the falling edge, return just after the rising edge
  // that consumed it so outputs reflect that sample.
  task automatic pix(input int x, input int y, input logic de,
                     input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    @(negedge clk_pix);
    sim_rst_n = 1'b1;
    sdl_sx = 10'(x); sdl_sy = 10'(y); sdl_de = de;
    sdl_r = r; sdl_g = g; sdl_b = b;
    @(posedge clk_pix);
    #1;
  endtask

  // One reset cycle carrying an arbitrary drawn sample that must be ignored.
  task automatic rst_cycle(input int x, input int y);
    @(negedge clk_pix);
    sim_rst_n = 1'b0;
    sdl_sx = 10'(x); sdl_sy = 10'(y); sdl_de = 1'b1;
    sdl_r = 8'h11; sdl_g = 8'h22; sdl_b = 8'h33;
    @(posedge clk_pix);
    #1;
  endtask

  // kind 0: blank, 1: blue square, 2: full white
  task automatic gen(input int kind, input int x, input int y, output logic de,
                     output logic [7:0] r, output logic [7:0] g, output logic [7:0] b);
    de = 1'b0; r = 8'h00; g = 8'h00; b = 8'h00;
    if (kind == 1 && x >= 5 && x <= 14 && y >= 3 && y <= 12) begin
      de = 1'b1; b = 8'hFF;
    end else if (kind == 2) begin
      de = 1'b1; r = 8'hFF; g = 8'hFF; b = 8'hFF;
    end
  endtask

  // Send raster indices first..last; counts frame_done pulses seen.
  task automatic stream(input int kind, input int first, input int last);
    logic de;
    logic [7:0] r, g, b;
    for (int i = first; i <= last; i++) begin
      gen(kind, i % H, i / H, de, r, g, b);
      pix(i % H, i / H, de, r, g, b);
      if (frame_done === 1'b1) done_cnt++;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, ".locked"}, 32'(locked), 0);
    chk({tag, ".frame_done"}, 32'(frame_done), 0);
    chk({tag, ".pix_count"}, 32'(pix_count), 0);
    chk({tag, ".bbox_valid"}, 32'(bbox_valid), 0);
    chk({tag, ".bbox_x1"}, 32'(bbox_x1), 0);
    chk({tag, ".bbox_y1"}, 32'(bbox_y1), 0);
    chk({tag, ".sum_rgb"}, sum_rgb, 0);
    chk({tag, ".frame_cnt"}, 32'(frame_cnt), 0);
    chk({tag, ".seq_err"}, 32'(seq_err), 0);
  endtask

  // Full frame from (0,0), then check the publication seen right after the
  // last pixel's edge.
  task automatic full_frame(input string tag, input int kind, input int cnt,
                            input int bv, input int x0, input int x1, input int y0,
                            input int y1, input int sum, input int fcnt, input int serr);
    done_cnt = 0;
    stream(kind, 0, LAST);
    $display("frame %s: done=%0d count=%0d box=(%0d,%0d,%0d,%0d) sum=%0d fcnt=%0d",
             tag, frame_done, pix_count, bbox_x0, bbox_x1, bbox_y0, bbox_y1,
             sum_rgb, frame_cnt);
    chk({tag, ".done_now"}, 32'(frame_done), 1);
    chk({tag, ".done_pulses"}, done_cnt, 1);
    chk({tag, ".pix_count"}, 32'(pix_count), cnt);
    chk({tag, ".bbox_valid"}, 32'(bbox_valid), bv);
    chk({tag, ".bbox_x0"}, 32'(bbox_x0), x0);
    chk({tag, ".bbox_x1"}, 32'(bbox_x1), x1);
    chk({tag, ".bbox_y0"}, 32'(bbox_y0), y0);
    chk({tag, ".bbox_y1"}, 32'(bbox_y1), y1);
    chk({tag, ".sum_rgb"}, sum_rgb, sum);
    chk({tag, ".frame_cnt"}, 32'(frame_cnt), fcnt);
    chk({tag, ".seq_err"}, 32'(seq_err), serr);
    chk({tag, ".locked"}, 32'(locked), 1);
  endtask

  initial begin
    // Reset held for several cycles with a (0,0) drawn sample on the bus.
    sim_rst_n = 1'b0;
    sdl_sx = '0; sdl_sy = '0; sdl_de = 1'b1;
    sdl_r = 8'hAA; sdl_g = 8'hBB; sdl_b = 8'hCC;
    repeat (3) @(posedge clk_pix);
    #1;
    check_outputs_zero("reset");

    // First sample (0,0) locks on the next edge.
    done_cnt = 0;
    stream(1, 0, 0);
    chk("lock_first", 32'(locked), 1);
    stream(1, 1, LAST);
    chk("sq1.done_now", 32'(frame_done), 1);
    chk("sq1.done_pulses", done_cnt, 1);
    chk("sq1.pix_count", 32'(pix_count), 100);
    chk("sq1.bbox", {bbox_x0[7:0], bbox_x1[7:0], bbox_y0[7:0], bbox_y1[7:0]},
        {8'd5, 8'd14, 8'd3, 8'd12});
    chk("sq1.bbox_valid", 32'(bbox_valid), 1);
    chk("sq1.sum_rgb", sum_rgb, 25500);
    chk("sq1.frame_cnt", 32'(frame_cnt), 1);

    // Next frame's first sample: pulse must already be gone.
    full_frame("sq2", 1, 100, 1, 5, 14, 3, 12, 25500, 2, 0);
    full_frame("blank", 0, 0, 0, 0, 0, 0, 0, 0, 3, 0);
    full_frame("white", 2, 320, 1, 0, H - 1, 0, V - 1, 320 * 765, 4, 0);

    // Reset, then a stream that starts mid-frame at (7,4).
    rst_cycle(3, 3);
    check_outputs_zero("rst2");
    done_cnt = 0;
    stream(1, 4 * H + 7, LAST);
    chk("midstart.locked", 32'(locked), 0);
    chk("midstart.done_pulses", done_cnt, 0);
    full_frame("after_mid", 1, 100, 1, 5, 14, 3, 12, 25500, 1, 0);

    // Discontinuity: (11,5) right after (9,5).
    done_cnt = 0;
    stream(1, 0, 5 * H + 9);
    pix(11, 5, 1'b1, 8'h00, 8'h00, 8'hFF);
    chk("skip.seq_err", 32'(seq_err), 1);
    chk("skip.locked", 32'(locked), 0);
    stream(1, 5 * H + 12, LAST);
    chk("skip.done_pulses", done_cnt, 0);
    chk("skip.frame_cnt_held", 32'(frame_cnt), 1);
    full_frame("relock", 1, 100, 1, 5, 14, 3, 12, 25500, 2, 1);

    // Single-cycle reset in the middle of a frame at (11,8).
    done_cnt = 0;
    stream(1, 0, 8 * H + 10);
    rst_cycle(11, 8);
    check_outputs_zero("rst_mid");
    stream(1, 8 * H + 12, LAST);
    chk("rst_mid.done_pulses", done_cnt, 0);
    chk("rst_mid.locked_after", 32'(locked), 0);
    full_frame("post_rst", 1, 100, 1, 5, 14, 3, 12, 25500, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pixel_stream_monitor.md
Name: pixel_stream_monitor

Overview:
- Sink-side consumer of the raster pixel stream that the game top drives to the SDL simulation (sdl_sx/sdl_sy/sdl_de/sdl_r/g/b).
- Locks onto the raster and checks that it is continuous.
- Accumulates per-frame statistics: drawn-pixel count, bounding box of drawn pixels, and colour checksum.
- Publishes the statistics once per frame with a one-cycle done pulse. Used as a self-check in simulation and as a debug tap on hardware.

Parameters:
- H_RES, 640, active pixels per line; valid sx range 0..H_RES-1
- V_RES, 480, active lines per frame; valid sy range 0..V_RES-1
- CNT_W, 19, width of the drawn-pixel counter; must hold H_RES*V_RES

Ports:
- clk_pix  in  1  pixel clock; all logic on rising edge
- sim_rst_n  in  1  synchronous active-low reset
- sdl_sx  in  10  current pixel x
- sdl_sy  in  10  current pixel y
- sdl_de  in  1  pixel is drawn
- sdl_r  in  8  red
- sdl_g  in  8  green
- sdl_b  in  8  blue
- locked  out  1  high while tracking a continuous raster
- frame_done  out  1  one-cycle pulse: a complete frame's results were just published
- pix_count  out  CNT_W  number of de=1 pixels in the last complete frame
- bbox_valid  out  1  last complete frame had at least one de=1 pixel
- bbox_x0  out  10  min x of drawn pixels; 0 if none
- bbox_x1  out  10  max x of drawn pixels; 0 if none
- bbox_y0  out  10  min y of drawn pixels; 0 if none
- bbox_y1  out  10  max y of drawn pixels; 0 if none
- sum_rgb  out  32  sum of (r+g+b) over de=1 pixels, modulo 2^32
- frame_cnt  out  16  complete frames published; wraps at 65535 to 0
- seq_err  out  1  sticky: raster discontinuity seen since reset

Behaviour:
- Reset (sim_rst_n=0 at a clock edge):
  - All outputs and accumulators go to 0; FSM goes to HUNT.
  - The input sampled in the reset cycle is ignored.
  - A reset mid-frame discards the partial frame; no frame_done is produced.
- FSM states: HUNT, TRACK. locked = (state==TRACK), registered.
- HUNT:
  - Inputs are ignored until a sample with sx==0 and sy==0.
  - On that sample: go to TRACK and seed the accumulators with that pixel. Seeding means count = de, box = (0,0,0,0) if de, sum = de ? r+g+b : 0.
- TRACK:
  - Expected coordinate = previous sample's coordinate advanced in raster order. x+1; at x==H_RES-1, x=0 and y+1; at (H_RES-1,V_RES-1), wrap to (0,0).
  - Match: accumulate. count += de. If de: min/max update of the box, and sum += r+g+b (10-bit zero-extended add).
  - Mismatch (includes out-of-range sx/sy): set seq_err and go to HUNT. Discard the accumulators; no frame_done and no output update.
  - A mismatching sample that is itself (0,0) is still an error. Re-lock happens from HUNT on the next (0,0) sample, not on the same cycle.
- End of frame: when the matched sample is (H_RES-1,V_RES-1), on that same edge:
  - Results, including that last pixel, are registered into the outputs.
  - frame_done is driven high for exactly the following cycle; latency is 1 cycle from the last pixel's sample edge.
  - frame_cnt increments.
  - Accumulators clear so that the next (0,0) sample seeds the new frame.
  - Outputs hold until the next publication or reset.
- No de=1 pixels in a frame: publish bbox_valid=0, bbox_*=0, pix_count=0, sum_rgb=0.
- sum_rgb wraps silently. pix_count cannot overflow with the default parameters.
- seq_err clears only on reset. frame_done is never asserted in HUNT.
- The first frame after reset is published only if the raster starts at (0,0) and stays continuous.

Test Plan:
- Reset release, generator starts at (0,0). Blue 10x10 square with de over x 315..324, y 235..244, b=FF → locked=1 after the first sample. frame_done pulses 1 cycle after (639,479). pix_count=100, bbox=(315,324,235,244), bbox_valid=1, sum_rgb=25500, frame_cnt=1. Second identical frame gives identical results and frame_cnt=2.
- Frame with de=0 everywhere → frame_done pulse; pix_count=0, bbox_valid=0, all bbox_*=0, sum_rgb=0, seq_err=0.
- Full-screen white (de=1, rgb=FF,FF,FF) → pix_count=307200, bbox=(0,639,0,479), sum_rgb=235008000.
- Stream starts at (100,50) → locked=0 and no frame_done until (0,0) is seen. The first published frame is the first complete one; seq_err=0.
- During tracking, inject (201,10) after (199,10) → seq_err=1 on the next cycle and locked=0. No frame_done for that frame. Re-lock at the next (0,0); the following full frame publishes correctly and seq_err stays 1.
- Assert sim_rst_n=0 for 1 cycle at (320,240) → all outputs 0 and locked=0. Only a later complete frame starting at (0,0) publishes, with frame_cnt=1.
